// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed driver for an 8-digit, common-anode 7-segment display.
//   A slot counter divides clk into SCAN_DIV-cycle digit slots. The digit index
//   advances at each slot wrap. Each slot starts with BLANK_CYC cycles of all
//   anodes off, which suppresses ghosting between digits. The digit is lit for
//   the rest of the slot.
//
// Parameters
//   SCAN_DIV   clk cycles per digit slot (>= 2)
//   BLANK_CYC  dark cycles at the start of each slot (0 <= BLANK_CYC < SCAN_DIV)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         1 = scanning; 0 = display dark, slot counter and index frozen
//   digits     packed nibbles, digit i = digits[4i+3:4i], digit 0 rightmost
//   blank      blank[i]=1 turns off segments and dp of digit i
//   dp         dp[i]=1 lights the decimal point of digit i
//   anode      active-low one-hot digit enable
//   seg        active-low cathodes {g,f,e,d,c,b,a}
//   dp_n       active-low decimal point
//   rotate     one-cycle pulse marking the last cycle of each slot
//   digit_idx  digit that owns the current slot (state register, no latency)
module seg_scan_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] digits,
  input  logic [7:0]  blank,
  input  logic [7:0]  dp,
  output logic [7:0]  anode,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        rotate,
  output logic [2:0]  digit_idx
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  // Hex to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CW-1:0] cnt;
  logic          lit_p0;
  logic          show_p0;
  logic          wrap_p0;
  logic [3:0]    nib_p0;

  // With no dark gap the compare against zero is always true, so it is
  // elided rather than left as a constant comparison.
  if (BLANK_CYC == 0) begin : g_nogap
    assign lit_p0 = en;
  end else begin : g_gap
    localparam logic [CW-1:0] BLANK_V = CW'(BLANK_CYC);
    assign lit_p0 = en & (cnt >= BLANK_V);
  end

  assign wrap_p0 = en & (cnt == LAST);
  assign nib_p0  = digits[{digit_idx, 2'b00} +: 4];
  assign show_p0 = lit_p0 & ~blank[digit_idx];

  // ---- stage p0 -> registered outputs (1-cycle latency from cnt/digit_idx) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      digit_idx <= 3'd0;
      anode     <= 8'hFF;
      seg       <= 7'h7F;
      dp_n      <= 1'b1;
      rotate    <= 1'b0;
    end else begin
      rotate <= wrap_p0;
      // Anode derives from a single index, so at most one bit is ever low.
      anode  <= lit_p0 ? ~(8'h01 << digit_idx) : 8'hFF;
      seg    <= show_p0 ? decode7(nib_p0) : 7'h7F;
      dp_n   <= show_p0 ? ~dp[digit_idx] : 1'b1;
      if (en) begin
        if (cnt == LAST) begin
          cnt       <= '0;
          digit_idx <= digit_idx + 3'd1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
